// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the convolution engine and the
// pixel streamer that feeds it.
package cnn_pkg;

  localparam int DIM    = 28;
  localparam int PIXELS = DIM * DIM;
  localparam int AW     = 10;

  localparam logic [AW-1:0] PIX_LAST  = AW'(PIXELS - 1);
  localparam logic [AW-1:0] PIX_LIMIT = AW'(PIXELS);

  typedef enum logic [1:0] {
    IDLE,
    START,
    STREAM,
    WAIT_DONE
  } state_t;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return a < PIX_LIMIT;
  endfunction

endpackage

// File: rtl/pixel_streamer_if.sv
// Host/engine-facing signal bundle of pixel_streamer; the optional checksum
// output exists only when PIXEL_CHECKSUM_EN is defined.
interface pixel_streamer_if;
  import cnn_pkg::*;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          send;
  logic          conv_done;
  logic          busy;
  logic          conv_start;
  // pixel_valid qualifies pixel_out every cycle it is high; there is no ready:
  // the engine must take one pixel per cycle for the whole frame.
  logic [7:0]    pixel_out;
  logic          pixel_valid;
  logic          frame_done;
  logic          wr_err;
  state_t        dbg_state;
`ifdef PIXEL_CHECKSUM_EN
  logic [15:0]   checksum;

  modport master (
    output wr_en, wr_addr, wr_data, send, conv_done,
    input  busy, conv_start, pixel_out, pixel_valid, frame_done, wr_err,
           dbg_state, checksum
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, send, conv_done,
    output busy, conv_start, pixel_out, pixel_valid, frame_done, wr_err,
           dbg_state, checksum
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, send, conv_done,
    input  busy, conv_start, pixel_out, pixel_valid, frame_done, wr_err,
           dbg_state
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, send, conv_done,
    output busy, conv_start, pixel_out, pixel_valid, frame_done, wr_err,
           dbg_state
  );
`endif

endinterface

// File: rtl/pixel_streamer_image_buffer.sv
// DIM*DIM x 8 image RAM: one synchronous write port, one synchronous read
// port whose output register clears to zero whenever no read is issued.
module image_buffer
  import cnn_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_rd_valid
);

  logic [7:0] r_mem [PIXELS];
  logic [7:0] r_rd_data;
  logic       r_rd_valid;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Storage is never reset; only the output register is, so a mid-frame
  // reset blanks the pixel bus without disturbing the stored image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_data  <= i_rd_en ? r_mem[i_rd_addr] : 8'd0;
      r_rd_valid <= i_rd_en;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/pixel_streamer.sv
// Streams a stored DIM*DIM image to the convolution engine after a
// conv_start pulse. Define PIXEL_CHECKSUM_EN to add the checksum output.
module pixel_streamer
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  pixel_streamer_if.slave  bus
);

  state_t        r_state, w_next;
  logic [AW-1:0] r_ptr;
  logic          r_last;
  logic          r_frame_done;
  logic          r_wr_err;
  logic          w_wr_ok;
  logic          w_rd_en;
  logic [7:0]    w_pixel;
  logic          w_pixel_valid;

  assign w_wr_ok = bus.wr_en && (r_state == IDLE) && addr_ok(bus.wr_addr);

  // The read is issued one cycle before its pixel appears; r_last marks the
  // cycle in which the final pixel is on the bus and nothing is read.
  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      IDLE:      if (bus.send) w_next = START;
      START: begin
        w_rd_en = 1'b1;
        w_next  = STREAM;
      end
      STREAM: begin
        if (r_last) w_next = WAIT_DONE;
        else        w_rd_en = 1'b1;
      end
      WAIT_DONE: if (bus.conv_done) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_frame_done <= (r_state == WAIT_DONE) && bus.conv_done;
      r_wr_err     <= bus.wr_en && !w_wr_ok;
      if (r_state == START || r_state == STREAM) begin
        if (r_ptr != PIX_LAST) r_ptr  <= r_ptr + 1'b1;
        else                   r_last <= 1'b1;
      end else begin
        r_ptr  <= '0;
        r_last <= 1'b0;
      end
    end
  end

  image_buffer u_image_buffer (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_wr_ok),
    .i_wr_addr  (bus.wr_addr),
    .i_wr_data  (bus.wr_data),
    .i_rd_en    (w_rd_en),
    .i_rd_addr  (r_ptr),
    .o_rd_data  (w_pixel),
    .o_rd_valid (w_pixel_valid)
  );

`ifdef PIXEL_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_checksum <= '0;
    else if (r_state == START)   r_checksum <= '0;
    else if (w_pixel_valid)      r_checksum <= r_checksum + {8'd0, w_pixel};
  end

  assign bus.checksum = r_checksum;
`endif

  assign bus.busy        = (r_state != IDLE);
  assign bus.conv_start  = (r_state == START);
  assign bus.pixel_out   = w_pixel;
  assign bus.pixel_valid = w_pixel_valid;
  assign bus.frame_done  = r_frame_done;
  assign bus.wr_err      = r_wr_err;
  assign bus.dbg_state   = r_state;

endmodule
